// File: rtl/sic_dispatcher_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sic_dispatcher_pkg
//  Description : Packet type and opcode constants shared by the SIC dispatcher.
//  Revision    : 1.0
// ============================================================================
package sic_dispatcher_pkg;

    localparam logic [5:0] OPC_SPECIAL = 6'h00;
    localparam logic [5:0] FUNCT_JR    = 6'h08;

    typedef struct packed {
        logic        valid;
        logic [3:0]  issue_id;
        logic [5:0]  opcode;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [5:0]  funct;
        logic [31:0] pc;
    } sic_packet_t;

    function automatic logic is_jr(input sic_packet_t pkt);
        return (pkt.opcode == OPC_SPECIAL) && (pkt.funct == FUNCT_JR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sic_dispatch_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sic_dispatch_fifo
//  Description : Synchronous FIFO with flush; no bypass from push to pop.
//  Revision    : 1.0
// ============================================================================
module sic_dispatch_fifo #(
    parameter int  DEPTH = 4,
    parameter type T     = logic,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_push,
    input  T              i_push_data,
    input  logic          i_pop,
    output T              o_pop_data,
    input  logic          i_flush,
    output logic          o_full,
    output logic          o_empty,
    output logic [CW-1:0] o_count
);

    T              r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_full     = (r_count == CW'(DEPTH));
    assign o_empty    = (r_count == '0);
    assign o_count    = r_count;
    assign o_pop_data = r_mem[r_rd_ptr];
    assign w_do_push  = i_push && !o_full;
    assign w_do_pop   = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_push_data;
    end

endmodule
`default_nettype wire

// File: rtl/sic_dispatcher.sv
`default_nettype none
// ============================================================================
//  Module      : sic_dispatcher
//  Description : Buffers issued packets and hands each to one idle SIC in
//                round-robin order; stalls behind a JR until its redirect.
//  Revision    : 1.0
// ============================================================================
module sic_dispatcher
    import sic_dispatcher_pkg::*;
#(
    parameter int NUM_SIC  = 4,
    parameter int DEPTH    = 4,
    parameter int ID_WIDTH = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  sic_packet_t                        in_pkt,
    input  logic [NUM_SIC-1:0]                 sic_req,
    output sic_packet_t [NUM_SIC-1:0]          sic_pkt,
    input  logic [NUM_SIC-1:0]                 sic_redir_valid,
    input  logic [NUM_SIC-1:0][31:0]           sic_redir_pc,
    input  logic [NUM_SIC-1:0][ID_WIDTH-1:0]   sic_redir_id,
    output logic                               fe_redirect_valid,
    output logic [31:0]                        fe_redirect_pc,
    output logic                               jr_stall,
    output logic [$clog2(DEPTH):0]             occupancy
);

    localparam int SIC_W = (NUM_SIC > 1) ? $clog2(NUM_SIC) : 1;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic                      w_fifo_full;
    logic                      w_fifo_empty;
    logic [CW-1:0]             w_count;
    sic_packet_t               w_head;
    sic_packet_t               w_disp_pkt;
    logic                      w_push;
    logic                      w_pop;
    logic                      w_flush_now;
    logic [31:0]               w_flush_pc;
    logic [NUM_SIC-1:0]        w_eligible;
    logic                      w_any_eligible;
    logic [SIC_W-1:0]          w_target;
    logic [SIC_W-1:0]          w_rr_next;

    logic [NUM_SIC-1:0]        r_req_q;
    logic [SIC_W-1:0]          r_rr_ptr;
    sic_packet_t [NUM_SIC-1:0] r_sic_pkt;
    logic                      r_jr_stall;
    logic [ID_WIDTH-1:0]       r_jr_id;
    logic                      r_fe_valid;
    logic [31:0]               r_fe_pc;

    // Scanning from the top down leaves the lowest matching SIC as the winner.
    always_comb begin
        w_flush_now = 1'b0;
        w_flush_pc  = '0;
        for (int k = NUM_SIC - 1; k >= 0; k--) begin
            if (r_jr_stall && sic_redir_valid[k] && (sic_redir_id[k] == r_jr_id)) begin
                w_flush_now = 1'b1;
                w_flush_pc  = sic_redir_pc[k];
            end
        end
    end

    // A SIC requesting for two cycles with no pending strobe is in WAIT_PACKET.
    for (genvar k = 0; k < NUM_SIC; k++) begin : g_elig
        assign w_eligible[k] = sic_req[k] && r_req_q[k] && !r_sic_pkt[k].valid;
    end

    always_comb begin
        w_any_eligible = 1'b0;
        w_target       = '0;
        for (int i = NUM_SIC - 1; i >= 0; i--) begin
            if (w_eligible[(int'(r_rr_ptr) + i) % NUM_SIC]) begin
                w_any_eligible = 1'b1;
                w_target       = SIC_W'((int'(r_rr_ptr) + i) % NUM_SIC);
            end
        end
    end

    assign w_rr_next = (w_target == SIC_W'(NUM_SIC - 1)) ? '0 : w_target + 1'b1;

    always_comb begin
        w_disp_pkt       = w_head;
        w_disp_pkt.valid = 1'b1;
    end

    assign in_ready = !w_fifo_full && !w_flush_now;
    assign w_push   = in_valid && in_ready;
    assign w_pop    = !w_fifo_empty && !r_jr_stall && !w_flush_now && w_any_eligible;

    sic_dispatch_fifo #(
        .DEPTH (DEPTH),
        .T     (sic_packet_t)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_data (in_pkt),
        .i_pop       (w_pop),
        .o_pop_data  (w_head),
        .i_flush     (w_flush_now),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty),
        .o_count     (w_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_req_q    <= '0;
            r_rr_ptr   <= '0;
            r_sic_pkt  <= '0;
            r_jr_stall <= 1'b0;
            r_jr_id    <= '0;
            r_fe_valid <= 1'b0;
            r_fe_pc    <= '0;
        end else begin
            r_req_q    <= sic_req;
            r_fe_valid <= w_flush_now;
            if (w_flush_now) begin
                r_fe_pc    <= w_flush_pc;
                r_jr_stall <= 1'b0;
            end
            for (int k = 0; k < NUM_SIC; k++) begin
                r_sic_pkt[k].valid <= 1'b0;
            end
            if (w_pop) begin
                r_sic_pkt[w_target] <= w_disp_pkt;
                r_rr_ptr            <= w_rr_next;
                if (is_jr(w_head)) begin
                    r_jr_stall <= 1'b1;
                    r_jr_id    <= ID_WIDTH'(w_head.issue_id);
                end
            end
        end
    end

    assign sic_pkt           = r_sic_pkt;
    assign jr_stall          = r_jr_stall;
    assign fe_redirect_valid = r_fe_valid;
    assign fe_redirect_pc    = r_fe_pc;
    assign occupancy         = w_count;

endmodule
`default_nettype wire

// File: tb/tb_sic_dispatcher.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sic_dispatcher
//  Description : Directed self-checking bench for sic_dispatcher.
//  Revision    : 1.0
// ============================================================================
module tb_sic_dispatcher;
    import sic_dispatcher_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  in_valid;
    logic                  in_ready;
    sic_packet_t           in_pkt;
    logic [3:0]            sic_req;
    sic_packet_t [3:0]     sic_pkt;
    logic [3:0]            sic_redir_valid;
    logic [3:0][31:0]      sic_redir_pc;
    logic [3:0][3:0]       sic_redir_id;
    logic                  fe_redirect_valid;
    logic [31:0]           fe_redirect_pc;
    logic                  jr_stall;
    logic [2:0]            occupancy;

    int n_checks = 0;
    int n_errors = 0;

    sic_dispatcher #(.NUM_SIC(4), .DEPTH(4), .ID_WIDTH(4)) dut (
        .clk               (clk),
        .rst               (rst),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_pkt            (in_pkt),
        .sic_req           (sic_req),
        .sic_pkt           (sic_pkt),
        .sic_redir_valid   (sic_redir_valid),
        .sic_redir_pc      (sic_redir_pc),
        .sic_redir_id      (sic_redir_id),
        .fe_redirect_valid (fe_redirect_valid),
        .fe_redirect_pc    (fe_redirect_pc),
        .jr_stall          (jr_stall),
        .occupancy         (occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid        = 1'b0;
        sic_req         = '0;
        sic_redir_valid = '0;
        rst             = 1'b1;
        tick();
        rst             = 1'b0;
    endtask

    function automatic logic [3:0] vmask();
        logic [3:0] m;
        for (int k = 0; k < 4; k++) m[k] = sic_pkt[k].valid;
        return m;
    endfunction

    function automatic sic_packet_t mk(input int id, input bit jr);
        sic_packet_t p;
        p          = '0;
        p.valid    = 1'b1;
        p.issue_id = 4'(id);
        p.opcode   = OPC_SPECIAL;
        p.funct    = jr ? FUNCT_JR : 6'h21;
        p.rs       = 5'(id);
        p.pc       = 32'h0040_0000 + 32'(id * 4);
        return p;
    endfunction

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_pkt = '0; sic_req = '0;
        sic_redir_valid = '0; sic_redir_pc = '0; sic_redir_id = '0;
        tick(); tick();
        chk("rst_occ",       occupancy, 0);
        chk("rst_in_ready",  in_ready, 1);
        chk("rst_sic_zero",  (sic_pkt == '0), 1);
        chk("rst_fe_valid",  fe_redirect_valid, 0);
        chk("rst_fe_pc",     fe_redirect_pc, 0);
        chk("rst_jr_stall",  jr_stall, 0);
        rst = 1'b0;

        // Single packet, latency t+2, one-cycle strobe
        sic_req = 4'b0001; tick();
        in_valid = 1'b1; in_pkt = mk(3, 0); tick();
        in_valid = 1'b0;
        chk("t1_occ_push",   occupancy, 1);
        chk("t1_no_early",   vmask(), 4'b0000);
        tick();
        chk("t1_valid",      vmask(), 4'b0001);
        chk("t1_id",         sic_pkt[0].issue_id, 3);
        chk("t1_pc",         sic_pkt[0].pc, 32'h0040_000C);
        chk("t1_occ_pop",    occupancy, 0);
        sic_req = 4'b0000; tick();
        chk("t1_pulse",      vmask(), 4'b0000);

        // Four packets to four waiting SICs, then round-robin skip
        do_reset();
        sic_req = 4'b1111; in_valid = 1'b1; in_pkt = mk(0, 0); tick();
        in_pkt = mk(1, 0); tick();
        chk("t2_d0_mask",    vmask(), 4'b0001);
        chk("t2_d0_id",      sic_pkt[0].issue_id, 0);
        sic_req = 4'b1110; in_pkt = mk(2, 0); tick();
        chk("t2_d1_mask",    vmask(), 4'b0010);
        chk("t2_d1_id",      sic_pkt[1].issue_id, 1);
        sic_req = 4'b1100; in_pkt = mk(3, 0); tick();
        chk("t2_d2_mask",    vmask(), 4'b0100);
        chk("t2_d2_id",      sic_pkt[2].issue_id, 2);
        sic_req = 4'b1000; in_valid = 1'b0; tick();
        chk("t2_d3_mask",    vmask(), 4'b1000);
        chk("t2_d3_id",      sic_pkt[3].issue_id, 3);
        chk("t2_occ",        occupancy, 0);
        sic_req = 4'b0010; tick();
        in_valid = 1'b1; in_pkt = mk(4, 0); tick();
        in_valid = 1'b0; tick();
        chk("t2_d4_mask",    vmask(), 4'b0010);
        chk("t2_d4_id",      sic_pkt[1].issue_id, 4);
        sic_req = 4'b0000;

        // Fill with nobody requesting, then release through SIC2
        do_reset();
        in_valid = 1'b1;
        for (int i = 8; i < 12; i++) begin
            in_pkt = mk(i, 0);
            chk("t3_ready_fill", in_ready, 1);
            tick();
        end
        in_pkt = mk(12, 0);
        chk("t3_full_occ",   occupancy, 4);
        chk("t3_full_rdy",   in_ready, 0);
        tick();
        chk("t3_held_occ",   occupancy, 4);
        sic_req = 4'b0100; tick();
        chk("t3_wait_occ",   occupancy, 4);
        chk("t3_wait_mask",  vmask(), 4'b0000);
        tick();
        chk("t3_pop_mask",   vmask(), 4'b0100);
        chk("t3_pop_id",     sic_pkt[2].issue_id, 8);
        chk("t3_pop_occ",    occupancy, 3);
        chk("t3_pop_rdy",    in_ready, 1);
        sic_req = 4'b0000; tick();
        chk("t3_refill_occ", occupancy, 4);
        in_valid = 1'b0;

        // JR stall, ignored redirect, matching redirect with coincident push
        do_reset();
        in_valid = 1'b1; in_pkt = mk(5, 1); tick();
        in_pkt = mk(6, 0); tick();
        in_pkt = mk(7, 0); tick();
        in_valid = 1'b0;
        sic_req = 4'b1111; tick();
        tick();
        chk("t4_jr_mask",    vmask(), 4'b0001);
        chk("t4_jr_id",      sic_pkt[0].issue_id, 5);
        chk("t4_jr_stall",   jr_stall, 1);
        chk("t4_jr_occ",     occupancy, 2);
        sic_req = 4'b1110; tick(); tick();
        chk("t4_stall_mask", vmask(), 4'b0000);
        chk("t4_stall_occ",  occupancy, 2);
        sic_redir_valid = 4'b0010; sic_redir_id[1] = 4'd9; sic_redir_pc[1] = 32'hDEAD_0000;
        #1;
        chk("t4_nm_ready",   in_ready, 1);
        tick();
        chk("t4_nm_fe",      fe_redirect_valid, 0);
        chk("t4_nm_stall",   jr_stall, 1);
        chk("t4_nm_occ",     occupancy, 2);
        sic_redir_valid = 4'b1100;
        sic_redir_id[2] = 4'd5; sic_redir_pc[2] = 32'h0040_0020;
        sic_redir_id[3] = 4'd5; sic_redir_pc[3] = 32'h00BA_D000;
        in_valid = 1'b1; in_pkt = mk(13, 0);
        #1;
        chk("t5_flush_rdy",  in_ready, 0);
        tick();
        chk("t5_fe_valid",   fe_redirect_valid, 1);
        chk("t5_fe_pc",      fe_redirect_pc, 32'h0040_0020);
        chk("t5_occ",        occupancy, 0);
        chk("t5_stall",      jr_stall, 0);
        chk("t5_no_pop",     vmask(), 4'b0000);
        sic_redir_valid = 4'b0000;
        #1;
        chk("t5_post_rdy",   in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk("t5_fe_pulse",   fe_redirect_valid, 0);
        chk("t5_push_occ",   occupancy, 1);
        tick();
        chk("t5_d_mask",     vmask(), 4'b0010);
        chk("t5_d_id",       sic_pkt[1].issue_id, 13);
        sic_req = 4'b0000;

        // Reset while stalled with three packets queued
        do_reset();
        in_valid = 1'b1; in_pkt = mk(1, 1); tick();
        in_pkt = mk(2, 0); tick();
        in_pkt = mk(3, 0); tick();
        in_pkt = mk(4, 0); tick();
        in_valid = 1'b0;
        sic_req = 4'b0001; tick(); tick();
        sic_req = 4'b0000;
        chk("t6_pre_stall",  jr_stall, 1);
        chk("t6_pre_occ",    occupancy, 3);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("t6_rst_occ",    occupancy, 0);
        chk("t6_rst_rdy",    in_ready, 1);
        chk("t6_rst_stall",  jr_stall, 0);
        chk("t6_rst_sic",    (sic_pkt == '0), 1);
        chk("t6_rst_fe",     fe_redirect_valid, 0);
        sic_req = 4'b1111; tick();
        in_valid = 1'b1; in_pkt = mk(6, 0); tick();
        in_valid = 1'b0; tick();
        chk("t6_d_mask",     vmask(), 4'b0001);
        chk("t6_d_id",       sic_pkt[0].issue_id, 6);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
